// File: rtl/fifo_rd_packer.sv
// Read-domain consumer of the async FIFO: stages FIFO words and packs PACK of them per output beat.
// Define FIFO_RD_PACK_TIMEOUT_EN to flush a partial beat after TIMEOUT idle cycles.
module fifo_rd_packer #(
  parameter int WIDTH   = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  rinc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]       m_keep
);

  localparam int CW = $clog2(PACK + 1);

  logic                  inflight_q;
  logic [WIDTH-1:0]      stageMem_q [2];
  logic                  stageHead_q, stageHead_d;
  logic [1:0]            stageCnt_q, stageCnt_d;
  logic                  stageTail;
  logic [WIDTH*PACK-1:0] accData_q, accData_d;
  logic [CW-1:0]         accCnt_q, accCnt_d;
  logic [CW-1:0]         laneIdx;
  logic                  mValid_q, mValid_d;
  logic [WIDTH*PACK-1:0] mData_q, mData_d;
  logic [PACK-1:0]       mKeep_q, mKeep_d;
  logic [PACK-1:0]       keepMask;
  logic                  accFull, slotFree, xfer, pop;
  logic [2:0]            occupancy;

  assign accFull  = (accCnt_q == CW'(PACK));
  assign slotFree = !mValid_q || m_ready;

`ifdef FIFO_RD_PACK_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idleCnt_q, idleCnt_d;
  logic          flushDue;

  // Idle counter saturates at TIMEOUT so a long wait for the output slot keeps the flush pending.
  assign flushDue = (idleCnt_q == IW'(TIMEOUT)) && (accCnt_q != '0) && !accFull;
  assign xfer     = slotFree && (accFull || flushDue);

  always_comb begin
    idleCnt_d = idleCnt_q;
    if (pop || xfer) begin
      idleCnt_d = '0;
    end else if ((accCnt_q != '0) && !accFull && (idleCnt_q != IW'(TIMEOUT))) begin
      idleCnt_d = idleCnt_q + IW'(1);
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      idleCnt_q <= '0;
    end else begin
      idleCnt_q <= idleCnt_d;
    end
  end
`else
  assign xfer = slotFree && accFull;
`endif

  assign pop = (stageCnt_q != 2'd0) && (!accFull || xfer);

  // Words already staged or returning from the RAM count against the 2-entry buffer.
  assign occupancy = {1'b0, stageCnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rinc      = !rrst && !rempty && (occupancy < 3'd2);

  assign stageTail = stageHead_q ^ stageCnt_q[0];

  always_comb begin
    stageHead_d = pop ? ~stageHead_q : stageHead_q;
    stageCnt_d  = stageCnt_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  // A pop coinciding with a transfer lands in lane 0 of the freshly cleared accumulator.
  assign laneIdx = xfer ? '0 : accCnt_q;

  always_comb begin
    accData_d = xfer ? '0 : accData_q;
    accCnt_d  = xfer ? '0 : accCnt_q;
    if (pop) begin
      for (int k = 0; k < PACK; k++) begin
        if (int'(laneIdx) == k) begin
          accData_d[k*WIDTH +: WIDTH] = stageMem_q[stageHead_q];
        end
      end
      accCnt_d = laneIdx + CW'(1);
    end
  end

  always_comb begin
    keepMask = '0;
    for (int k = 0; k < PACK; k++) begin
      keepMask[k] = (k < int'(accCnt_q));
    end
  end

  always_comb begin
    mValid_d = mValid_q;
    mData_d  = mData_q;
    mKeep_d  = mKeep_q;
    if (xfer) begin
      mValid_d = 1'b1;
      mData_d  = accData_q;
      mKeep_d  = keepMask;
    end else if (m_ready) begin
      mValid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      inflight_q    <= 1'b0;
      stageHead_q   <= 1'b0;
      stageCnt_q    <= 2'd0;
      stageMem_q[0] <= '0;
      stageMem_q[1] <= '0;
      accData_q     <= '0;
      accCnt_q      <= '0;
      mValid_q      <= 1'b0;
      mData_q       <= '0;
      mKeep_q       <= '0;
    end else begin
      inflight_q  <= rinc;
      stageHead_q <= stageHead_d;
      stageCnt_q  <= stageCnt_d;
      if (inflight_q) begin
        stageMem_q[stageTail] <= rdata;
      end
      accData_q <= accData_d;
      accCnt_q  <= accCnt_d;
      mValid_q  <= mValid_d;
      mData_q   <= mData_d;
      mKeep_q   <= mKeep_d;
    end
  end

  assign m_valid = mValid_q;
  assign m_data  = mData_q;
  assign m_keep  = mKeep_q;

  stageOverflow: assert property (@(posedge rclk) disable iff (rrst)
    !(inflight_q && !pop && (stageCnt_q == 2'd2)));

  paramLegal: assert property (@(posedge rclk) (PACK >= 2) && (TIMEOUT >= 1));

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: emulates the FIFO read port, models beats as groups of words.
module tb_fifo_rd_packer;

  localparam int WIDTH   = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 16;
  localparam int DW      = WIDTH * PACK;

  typedef struct {
    logic [DW-1:0]   data;
    logic [PACK-1:0] keep;
  } beat_t;

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic             rempty = 1'b1;
  logic [WIDTH-1:0] rdata = '0;
  logic             rinc;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DW-1:0]    m_data;
  logic [PACK-1:0]  m_keep;

  beat_t            expQ[$];
  logic [WIDTH-1:0] srcQ[$];
  logic [WIDTH-1:0] modelAcc[$];
  int               riseQ[$];

  int               vectorCount = 0;
  int               missCount = 0;
  int               cyc = 0;
  int               firstRincCyc = -1;
  int               rincSeen = 0;
  bit               holdEmpty = 1'b0;
  bit               throughputCheck = 1'b0;
  bit               firstArmed = 1'b0;
  bit               readPending = 1'b0;
  logic [WIDTH-1:0] pendingWord = '0;

  fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK), .TIMEOUT(TIMEOUT)) dut (
    .rclk   (rclk),
    .rrst   (rrst),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_keep (m_keep)
  );

  always #5 rclk = ~rclk;

  always @(posedge rclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: every PACK consecutive words read from the FIFO form one little-endian beat.
  task automatic applyStimulus(input logic [WIDTH-1:0] w);
    beat_t b;
    srcQ.push_back(w);
    modelAcc.push_back(w);
    if (modelAcc.size() == PACK) begin
      b.data = '0;
      b.keep = '1;
      foreach (modelAcc[k]) b.data[k*WIDTH +: WIDTH] = modelAcc[k];
      expQ.push_back(b);
      modelAcc.delete();
    end
  endtask

`ifdef FIFO_RD_PACK_TIMEOUT_EN
  task automatic modelFlush();
    beat_t b;
    if (modelAcc.size() > 0) begin
      b.data = '0;
      b.keep = '0;
      foreach (modelAcc[k]) begin
        b.data[k*WIDTH +: WIDTH] = modelAcc[k];
        b.keep[k] = 1'b1;
      end
      expQ.push_back(b);
      modelAcc.delete();
    end
  endtask
`endif

  task automatic tickN(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic waitDrain(input string name, input int maxCyc);
    int n;
    n = 0;
    while ((expQ.size() != 0 || srcQ.size() != 0) && n < maxCyc) begin
      @(posedge rclk);
      #1;
      n++;
    end
    tickN(2);
    checkOutput(name, expQ.size(), 0);
  endtask

  // FIFO read port: rdata is registered, appearing the cycle after an accepted rinc.
  initial begin
    forever begin
      @(negedge rclk);
      if (rrst) begin
        readPending = 1'b0;
      end else if (readPending) begin
        rdata = pendingWord;
        readPending = 1'b0;
      end
      rempty = holdEmpty || (srcQ.size() == 0);
      #3;
      if (throughputCheck && !rempty) checkOutput("rinc_sustained", rinc, 1);
      if (rinc === 1'b1) begin
        checkOutput("rinc_vs_rempty", rempty, 0);
        rincSeen++;
        if (firstArmed) begin
          firstRincCyc = cyc;
          firstArmed = 1'b0;
        end
        if (!rempty && srcQ.size() > 0) begin
          pendingWord = srcQ.pop_front();
          readPending = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each completed beat and checks hold behaviour under stall.
  initial begin
    logic            prevStall;
    logic            prevValid;
    logic [DW-1:0]   prevData;
    logic [PACK-1:0] prevKeep;
    beat_t           e;
    prevStall = 1'b0;
    prevValid = 1'b0;
    prevData  = '0;
    prevKeep  = '0;
    forever begin
      @(negedge rclk);
      #4;
      if (rrst) begin
        prevStall = 1'b0;
        prevValid = 1'b0;
      end else begin
        if (m_valid && !prevValid) riseQ.push_back(cyc);
        if (prevStall) begin
          checkOutput("stall_valid_held", m_valid, 1);
          checkOutput("stall_data_held", m_data, prevData);
          checkOutput("stall_keep_held", m_keep, prevKeep);
        end
        if (m_valid && m_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_beat", m_valid, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("beat_data", m_data, e.data);
            checkOutput("beat_keep", m_keep, e.keep);
          end
        end
        prevStall = m_valid && !m_ready;
        prevValid = m_valid;
        prevData  = m_data;
        prevKeep  = m_keep;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    int gap;
    int guard;

    rrst = 1'b1;
    tickN(3);
    checkOutput("reset_rinc", rinc, 0);
    checkOutput("reset_valid", m_valid, 0);
    checkOutput("reset_data", m_data, 0);
    checkOutput("reset_keep", m_keep, 0);
    rrst = 1'b0;
    tickN(2);

    $display("[TB] eight words, continuous ready");
    m_ready = 1'b1;
    riseQ.delete();
    firstArmed = 1'b1;
    for (int w = 1; w <= 8; w++) applyStimulus(WIDTH'(w));
    waitDrain("t1_drain", 100);
    checkOutput("t1_beat_count", riseQ.size(), 2);
    if (riseQ.size() >= 2) begin
      checkOutput("t1_first_latency", riseQ[0] - firstRincCyc, PACK + 3);
      checkOutput("t1_second_latency", riseQ[1] - firstRincCyc, 2 * PACK + 3);
    end

    $display("[TB] twelve words with stalled output");
    m_ready = 1'b0;
    for (int w = 0; w < 12; w++) applyStimulus(WIDTH'(8'h11 + w));
    guard = 0;
    while (!m_valid && guard < 50) begin
      tickN(1);
      guard++;
    end
    checkOutput("t2_first_valid", m_valid, 1);
    tickN(10);
    checkOutput("t2_rinc_stalled", rinc, 0);
    checkOutput("t2_words_left", srcQ.size(), 12 - (3 * PACK - 2));
    m_ready = 1'b1;
    waitDrain("t2_drain", 100);

    $display("[TB] sixteen words, sustained throughput");
    riseQ.delete();
    throughputCheck = 1'b1;
    for (int w = 0; w < 16; w++) applyStimulus(WIDTH'(8'h20 + w));
    waitDrain("t3_drain", 100);
    throughputCheck = 1'b0;
    checkOutput("t3_beat_count", riseQ.size(), 4);
    for (int i = 1; i < riseQ.size(); i++) checkOutput("t3_beat_spacing", riseQ[i] - riseQ[i-1], PACK);

    $display("[TB] six words then empty");
    riseQ.delete();
    for (int w = 1; w <= 6; w++) applyStimulus(WIDTH'(w));
`ifdef FIFO_RD_PACK_TIMEOUT_EN
    modelFlush();
    tickN(60);
    checkOutput("t4_beat_count", riseQ.size(), 2);
`else
    tickN(60);
    checkOutput("t4_beat_count", riseQ.size(), 1);
`endif
    checkOutput("t4_pending", expQ.size(), 0);
    applyStimulus(8'h07);
    applyStimulus(8'h08);
`ifdef FIFO_RD_PACK_TIMEOUT_EN
    modelFlush();
`endif
    waitDrain("t4_drain", 100);

    $display("[TB] reset in mid-operation");
    m_ready = 1'b0;
    for (int w = 0; w < 12; w++) applyStimulus(WIDTH'(8'h40 + w));
    tickN(8);
    #1;
    rrst = 1'b1;
    #1;
    checkOutput("t5_async_rinc", rinc, 0);
    checkOutput("t5_async_valid", m_valid, 0);
    checkOutput("t5_async_data", m_data, 0);
    checkOutput("t5_async_keep", m_keep, 0);
    srcQ.delete();
    modelAcc.delete();
    expQ.delete();
    tickN(2);
    rrst = 1'b0;
    tickN(1);
    m_ready = 1'b1;
    for (int w = 0; w < 4; w++) applyStimulus(WIDTH'(8'hA1 + w));
    waitDrain("t5_drain", 100);

    $display("[TB] rempty held high");
    base = rincSeen;
    tickN(20);
    checkOutput("t6_idle_rinc", rincSeen - base, 0);
    holdEmpty = 1'b1;
    for (int w = 0; w < 4; w++) applyStimulus(WIDTH'(8'hC0 + w));
    tickN(20);
    checkOutput("t6_gated_rinc", rincSeen - base, 0);
    checkOutput("t6_valid_low", m_valid, 0);
    holdEmpty = 1'b0;
    waitDrain("t6_drain", 100);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 3; r++) begin
      n = PACK * $urandom_range(10, 25);
      for (int i = 0; i < n; i++) applyStimulus(WIDTH'($urandom));
      gap = 0;
      guard = 0;
      while ((expQ.size() != 0 || srcQ.size() != 0) && guard < 4000) begin
        if (gap > 0) begin
          gap--;
          holdEmpty = 1'b1;
        end else if ($urandom_range(0, 7) == 0) begin
          gap = $urandom_range(0, 4);
          holdEmpty = 1'b1;
        end else begin
          holdEmpty = 1'b0;
        end
        m_ready = ($urandom_range(0, 3) != 0);
        tickN(1);
        guard++;
      end
      holdEmpty = 1'b0;
      m_ready = 1'b1;
      waitDrain("rand_drain", 100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
